// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Sends start bit, DATA_WIDTH data bits LSB first, an optional parity bit and
// one or two stop bits. Every bit is held for Prescale clock cycles (0 acts as 1).
// Frame settings are captured when a word is loaded, so port changes during a
// frame do not affect it.
// Optional build macro UART_TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO in
// front of the serialiser. Only the data word is queued. The frame settings
// are read from the ports when the word leaves the FIFO.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   Prescale       in   clock cycles per bit
//   P_DATA         in   parallel data word
//   Data_Valid     in   P_DATA valid; a word transfers when Data_Valid && Data_Ready
//   Data_Ready     out  a word can be accepted this cycle
//   parity_enable  in   add a parity bit after the data bits
//   parity_type    in   0 even, 1 odd
//   stop_bits      in   0 one stop bit, 1 two stop bits
//   busy           out  frame in progress (or word queued)
//   TX_OUT         out  registered serial line, idle high
//
// state    | meaning
// S_IDLE   | line high, waiting for a word
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit over the latched data
// S_STOP   | stop bit(s), high; the last cycle may load the next word
module uart_tx_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  output logic                      Data_Ready,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      stop_bits,
  output logic                      busy,
  output logic                      TX_OUT
);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] ONE_B = BIT_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] ZERO_P = '0;
  localparam logic [PRESCALE_WIDTH-1:0] ONE_P = PRESCALE_WIDTH'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]                state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_nxt;
  logic [PRESCALE_WIDTH-1:0] last_cnt, last_cnt_nxt;
  logic [BIT_W-1:0]          bit_idx, bit_nxt;
  logic                      stop_idx, stop_idx_nxt;
  logic [DATA_WIDTH-1:0]     data_r, data_nxt;
  logic                      par_en, par_en_nxt;
  logic                      par_odd, par_odd_nxt;
  logic                      two_stop, two_stop_nxt;
  logic                      tx_nxt;
  logic                      bit_done, fsm_free, load;
  logic [DATA_WIDTH-1:0]     load_data;

  // last_cnt holds P-1, so the end of a bit is a single compare.
  assign bit_done = (cnt == last_cnt);
  // The serialiser can take a new word while idle, or in the last cycle of the last stop bit.
  assign fsm_free = (state == S_IDLE) ||
                    ((state == S_STOP) && bit_done && (stop_idx == two_stop));

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  push, pop, full, empty;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign Data_Ready = !full;
  assign push       = Data_Valid && !full;
  assign pop        = fsm_free && !empty;
  assign load       = pop;
  assign load_data  = mem[rd_ptr];
  assign busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= P_DATA;
  end
`else
  assign Data_Ready = fsm_free;
  assign load       = Data_Valid && fsm_free;
  assign load_data  = P_DATA;
  assign busy       = (state != S_IDLE);
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_cnt_nxt = last_cnt;
    bit_nxt      = bit_idx;
    stop_idx_nxt = stop_idx;
    data_nxt     = data_r;
    par_en_nxt   = par_en;
    par_odd_nxt  = par_odd;
    two_stop_nxt = two_stop;
    tx_nxt       = 1'b1;

    if (state != S_IDLE) cnt_nxt = bit_done ? ZERO_P : cnt + ONE_P;

    case (state)
      S_START: if (bit_done) begin
        state_nxt = S_DATA;
        bit_nxt   = '0;
      end
      S_DATA: if (bit_done) begin
        if (bit_idx == LAST_BIT) begin
          state_nxt    = par_en ? S_PARITY : S_STOP;
          stop_idx_nxt = 1'b0;
        end else begin
          bit_nxt = bit_idx + ONE_B;
        end
      end
      S_PARITY: if (bit_done) begin
        state_nxt    = S_STOP;
        stop_idx_nxt = 1'b0;
      end
      S_STOP: if (bit_done) begin
        if (stop_idx != two_stop) stop_idx_nxt = 1'b1;
        else                      state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A load replaces whatever the frame logic above chose. fsm_free only
    // allows it from idle or from the very last stop cycle.
    if (load) begin
      state_nxt    = S_START;
      cnt_nxt      = ZERO_P;
      data_nxt     = load_data;
      par_en_nxt   = parity_enable;
      par_odd_nxt  = parity_type;
      two_stop_nxt = stop_bits;
      last_cnt_nxt = (Prescale == ZERO_P) ? ZERO_P : Prescale - ONE_P;
    end

    // TX_OUT is a register. It is computed from the next state, so a
    // transfer on edge k already drives the start bit after that edge.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = data_nxt[bit_nxt];
      S_PARITY: tx_nxt = par_odd_nxt ? ~^data_nxt : ^data_nxt;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_r   <= '0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      two_stop <= 1'b0;
      TX_OUT   <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_cnt <= last_cnt_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_idx_nxt;
      data_r   <= data_nxt;
      par_en   <= par_en_nxt;
      par_odd  <= par_odd_nxt;
      two_stop <= two_stop_nxt;
      TX_OUT   <= tx_nxt;
    end
  end
endmodule
